regfile_mp_sb: RTL
==================

Name: regfile_mp_sb

Overview:
- Parametrised successor of the pipeline register file: DATA_W-bit by DEPTH-entry storage, NUM_RD combinational read ports, and one write port.
- Writes commit on the rising clock edge. A same-cycle write-to-read bypass replaces the falling-edge write trick.
- Adds an async reset clear and a per-register pending scoreboard. The decode stage uses the scoreboard to detect RAW hazards against in-flight producers.
- Sits between the ID stage (reads, reservations) and the WB stage (writes).

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, register address width
DEPTH, 32, number of implemented registers (must be at most 2**ADDR_W)
NUM_RD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 means register 0 reads as 0 and ignores writes and reservations
BYPASS, 1, 1 means a same-cycle write is forwarded to matching read ports

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
we  in  1  write enable (WB stage)
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W]
rdata  out  NUM_RD*DATA_W  read data; port i occupies bits [i*DATA_W +: DATA_W]
rsv_en  in  1  reserve destination (ID issue of a writing instruction)
rsv_addr  in  ADDR_W  register to mark pending
busy  out  NUM_RD  bit i set means raddr port i targets a pending register not being satisfied this cycle
pend_cnt  out  ADDR_W+1  number of registers currently pending

Behaviour:
- Reset (rst_n low, asynchronous): all registers cleared to 0, all pending bits cleared, pend_cnt = 0. rdata is therefore 0 and busy is 0 while in reset.
- Reset released mid-stream: the first rising edge after rst_n goes high is the first edge that may commit a write or reservation.
- Legal address: addr < DEPTH, and additionally addr != 0 when ZERO_REG = 1.
- Write: at the rising edge, if we is high and waddr is legal, the register at waddr takes wdata. Illegal waddr means no state change.
- Read is combinational with zero latency:
  - rdata_i = 0 if raddr_i is illegal, or if raddr_i = 0 with ZERO_REG = 1.
  - Else, if BYPASS = 1 and we is high and waddr = raddr_i, rdata_i = wdata.
  - Else rdata_i = the stored register value.
- Read ports are independent; any number of ports may share an address.
- Scoreboard update at the rising edge:
  - If we is high and waddr is legal, clear pending[waddr].
  - If rsv_en is high and rsv_addr is legal, set pending[rsv_addr].
  - Same address in the same cycle: the set wins (a newer producer replaces the retiring one).
  - Reserving an already-pending register leaves it pending; pend_cnt does not change.
  - A write to a non-pending register is legal and leaves pending unchanged.
- busy_i = pending[raddr_i] AND raddr_i legal AND NOT (BYPASS AND we AND waddr = raddr_i). A reservation in the current cycle does not affect busy until the next cycle.
- pend_cnt is a registered count. Per edge: +1 on a set of a previously clear bit, −1 on a clear of a previously set bit, net 0 on the simultaneous same-address case. It never exceeds DEPTH.
- Address wrap: none. High address bits beyond DEPTH are not aliased; such addresses are treated as illegal.

Decomposition:
- Shared package regfile_pkg holds the defaults: DATA_W, ADDR_W, DEPTH, the ZERO_REG and BYPASS constants, and a function legal_addr(addr, DEPTH, ZERO_REG).
- One sub-module, regfile_scoreboard, owns the pending bit vector, set/clear priority, pend_cnt and busy generation.
- The top level holds the storage array, the write logic and the read/bypass muxes.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse rst_n low for a partial cycle with no clock edge → rdata of r5 reads 0 immediately; pend_cnt = 0; busy = 0.
- Write and read: we=1, waddr=3, wdata=0x12345678 → after the edge, rdata0 with raddr0=3 reads 0x12345678. A write to r0 with 0xFFFFFFFF (ZERO_REG=1) → r0 reads 0.
- Bypass: r7 holds 0x11. In the same cycle drive we=1, waddr=7, wdata=0x22, raddr0=raddr1=7 → both rdata = 0x22 combinationally. With BYPASS=0 both read 0x11 until the edge.
- Hazard: rsv_en on r4 → next cycle busy0 = 1 for raddr0 = 4 and pend_cnt = 1. WB write to r4 in a later cycle → busy0 drops to 0 in that same cycle (bypass); after the edge pend_cnt = 0.
- Simultaneous set/clear: r9 pending; in one cycle drive we on r9 and rsv_en on r9 → after the edge r9 is still pending, pend_cnt unchanged, data updated.
- Illegal addresses with DEPTH=24: write to 30 is ignored; reading 30 gives 0 and busy 0; reserving 30 leaves pend_cnt unchanged. With ZERO_REG=1, reserving 0 leaves pend_cnt unchanged.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults and helpers for the multi-port register file
//               and its pending-register scoreboard.
//               - c_* constants: default geometry and feature switches
//               - legal_addr(): address legality check (range and zero reg)
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int c_data_w   = 32;
    localparam int c_addr_w   = 5;
    localparam int c_depth    = 32;
    localparam int c_num_rd   = 2;
    localparam int c_zero_reg = 1;
    localparam int c_bypass   = 1;

    // An address is legal when it names an implemented register. High
    // addresses beyond DEPTH are never aliased back into the array, and
    // register 0 is excluded when it is hard-wired to zero.
    function automatic logic legal_addr(input logic [31:0] addr,
                                        input int unsigned depth,
                                        input bit          zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 32'd0));
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending bits used by decode for RAW hazard
//               detection against in-flight producers.
//   clk, rst_n  : clock, asynchronous active-low reset
//   we, waddr   : retiring write (clears pending)
//   rsv_en/addr : destination reservation (sets pending, wins on collision)
//   raddr       : read addresses, NUM_RD packed ports
//   busy        : per read port, register pending and not satisfied now
//   pend_cnt    : registered number of pending registers
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = c_addr_w,
    parameter int DEPTH    = c_depth,
    parameter int NUM_RD   = c_num_rd,
    parameter int ZERO_REG = c_zero_reg,
    parameter int BYPASS   = c_bypass
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD-1:0]          busy,
    output logic [ADDR_W:0]            pend_cnt
);

    logic [DEPTH-1:0] r_pending;
    logic [ADDR_W:0]  r_cnt;
    logic [DEPTH-1:0] w_clr_hit;
    logic [DEPTH-1:0] w_set_hit;
    logic             w_clr_ok;
    logic             w_set_ok;
    logic             w_inc;
    logic             w_dec;

    assign w_clr_ok = we     && legal_addr(32'(waddr),    DEPTH, ZERO_REG != 0);
    assign w_set_ok = rsv_en && legal_addr(32'(rsv_addr), DEPTH, ZERO_REG != 0);

    // One-hot decode of the clear and set targets.
    for (genvar j = 0; j < DEPTH; j++) begin : g_dec
        assign w_clr_hit[j] = w_clr_ok && (waddr    == ADDR_W'(j));
        assign w_set_hit[j] = w_set_ok && (rsv_addr == ADDR_W'(j));
    end

    // Count moves only on real bit transitions. A clear that collides with
    // a set on the same register is cancelled, so the net change is that of
    // the set alone (zero if the bit was already pending).
    assign w_inc = |(~r_pending & w_set_hit);
    assign w_dec = |(r_pending & w_clr_hit & ~w_set_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
        end else begin
            // Set applied after clear: a newer producer replaces the retiring one.
            r_pending <= (r_pending & ~w_clr_hit) | w_set_hit;
            r_cnt     <= r_cnt + {{ADDR_W{1'b0}}, w_inc} - {{ADDR_W{1'b0}}, w_dec};
        end
    end

    assign pend_cnt = r_cnt;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        logic [ADDR_W-1:0] w_ra;
        logic [DEPTH-1:0]  w_match;
        logic              w_legal;
        logic              w_fwd;

        assign w_ra    = raddr[i*ADDR_W +: ADDR_W];
        assign w_legal = legal_addr(32'(w_ra), DEPTH, ZERO_REG != 0);
        // A producer retiring this very cycle satisfies the read via bypass.
        assign w_fwd   = (BYPASS != 0) && we && (waddr == w_ra);

        for (genvar j = 0; j < DEPTH; j++) begin : g_cmp
            assign w_match[j] = (w_ra == ADDR_W'(j));
        end

        assign busy[i] = |(r_pending & w_match) && w_legal && !w_fwd;
    end

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_mp_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp_sb
// Description : DATA_W x DEPTH register file with NUM_RD combinational read
//               ports, one rising-edge write port, same-cycle write-to-read
//               bypass and a pending-register scoreboard.
//   clk, rst_n  : clock, asynchronous active-low reset (clears everything)
//   we/waddr/wdata : write port from WB
//   raddr/rdata : NUM_RD packed read ports, port i at [i*W +: W]
//   rsv_en/rsv_addr : destination reservation from ID
//   busy        : per read port RAW hazard indication
//   pend_cnt    : number of pending registers
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = c_data_w,
    parameter int ADDR_W   = c_addr_w,
    parameter int DEPTH    = c_depth,
    parameter int NUM_RD   = c_num_rd,
    parameter int ZERO_REG = c_zero_reg,
    parameter int BYPASS   = c_bypass
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       rsv_en,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic [NUM_RD-1:0]          busy,
    output logic [ADDR_W:0]            pend_cnt
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_ok;

    // Register 0 under ZERO_REG is never legal, so it keeps its reset value.
    assign w_wr_ok = we && legal_addr(32'(waddr), DEPTH, ZERO_REG != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (waddr == ADDR_W'(j)) begin
                    r_mem[j] <= wdata;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_ra;
        logic [DATA_W-1:0] w_sel;
        logic              w_legal;
        logic              w_fwd;

        assign w_ra    = raddr[i*ADDR_W +: ADDR_W];
        assign w_legal = legal_addr(32'(w_ra), DEPTH, ZERO_REG != 0);
        // Forwarding is suppressed in reset so reads stay zero while held.
        assign w_fwd   = (BYPASS != 0) && rst_n && we && (waddr == w_ra);

        always_comb begin
            w_sel = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (w_ra == ADDR_W'(j)) begin
                    w_sel = r_mem[j];
                end
            end
        end

        assign rdata[i*DATA_W +: DATA_W] = !w_legal ? '0    :
                                           w_fwd    ? wdata :
                                                      w_sel;
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .raddr    (raddr),
        .busy     (busy),
        .pend_cnt (pend_cnt)
    );

endmodule : regfile_mp_sb
`default_nettype wire
